// File: rtl/gc_poll_scheduler_pkg.sv
// Shared encodings for the GameCube controller poll scheduler and its per-port trackers.
package gc_pkg;

   typedef enum logic [1:0] {
      CMD_PROBE = 2'd0,
      CMD_PAIR  = 2'd1,
      CMD_POLL  = 2'd2
   } cmd_op_t;

   typedef enum logic [1:0] {
      PS_ABSENT = 2'd0,
      PS_PAIR   = 2'd1,
      PS_POLL   = 2'd2
   } port_state_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_XMIT  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_NEXT  = 3'd4
   } sched_state_t;

   localparam logic [7:0] ID_WIRED      = 8'h09;
   localparam logic [7:0] ID_WB_UNREADY = 8'hA8;

   function automatic cmd_op_t op_for_state(input port_state_t s);
      case (s)
         PS_PAIR: return CMD_PAIR;
         PS_POLL: return CMD_POLL;
         default: return CMD_PROBE;
      endcase
   endfunction

endpackage

// File: rtl/gc_poll_scheduler_port_tracker.sv
// Link state of one controller port: absent/pair/poll, latched WaveBird ID, miss count, reinit latch.
module gc_port_tracker
   import gc_pkg::*;
#(
   parameter int MAX_MISSES = 3
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        force_reinit,
   input  logic        is_current,
   input  logic        next_strobe,
   input  logic        pair_done,
   input  logic        probe_rsp,
   input  logic        poll_rsp,
   input  logic        poll_timeout,
   input  logic [23:0] rsp_data,
   output port_state_t state,
   output logic [23:0] id,
   output logic        wavebird
);

   localparam int MISS_W = $clog2(MAX_MISSES + 1);

   port_state_t       state_q, state_d;
   logic [23:0]       id_q, id_d;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic              wb_q, wb_d;
   logic              pend_q, pend_d;
   logic              pend_now;
   logic              apply;

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      miss_d   = miss_q;
      wb_d     = wb_q;
      pend_now = pend_q | force_reinit;
      // A reinit on the port being serviced waits for NEXT so the transaction finishes cleanly.
      apply    = pend_now & (~is_current | next_strobe);
      pend_d   = pend_now & ~apply;
      if (apply) begin
         state_d = PS_ABSENT;
         miss_d  = '0;
         wb_d    = 1'b0;
      end else if (pair_done) begin
         state_d = PS_POLL;
         wb_d    = 1'b1;
         miss_d  = '0;
      end else if (probe_rsp) begin
         if (rsp_data[23:16] == ID_WIRED) begin
            state_d = PS_POLL;
            wb_d    = 1'b0;
            miss_d  = '0;
         end else if (rsp_data[23:16] == ID_WB_UNREADY) begin
            state_d = PS_ABSENT;
         end else begin
            state_d = PS_PAIR;
            id_d    = rsp_data;
         end
      end else if (poll_rsp) begin
         miss_d = '0;
      end else if (poll_timeout && (state_q == PS_POLL)) begin
         if (miss_q == MISS_W'(MAX_MISSES - 1)) begin
            state_d = PS_ABSENT;
            wb_d    = 1'b0;
            miss_d  = '0;
         end else begin
            miss_d = miss_q + MISS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PS_ABSENT;
         id_q    <= '0;
         miss_q  <= '0;
         wb_q    <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         miss_q  <= miss_d;
         wb_q    <= wb_d;
         pend_q  <= pend_d;
      end
   end

   assign state    = state_q;
   assign id       = id_q;
   assign wavebird = wb_q;

endmodule

// File: rtl/gc_poll_scheduler.sv
// Round-robin scheduler for the shared GameCube serial transmitter (probe / WaveBird pair / poll).
// Optional GC_RUMBLE_EN adds a rumble input whose bit for the target port rides in cmd_id[0] of POLL.
module gc_poll_scheduler
   import gc_pkg::*;
#(
   parameter int NUM_PORTS    = 4,
   parameter int FRAME_CYCLES = 1000000,
   parameter int RSP_TIMEOUT  = 50000,
   parameter int MAX_MISSES   = 3,
   parameter int PORT_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [NUM_PORTS-1:0] force_reinit,
`ifdef GC_RUMBLE_EN
   input  logic [NUM_PORTS-1:0] rumble,
`endif
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [PORT_W-1:0]    cmd_port,
   output logic [1:0]           cmd_op,
   output logic [23:0]          cmd_id,
   input  logic                 cmd_done,
   input  logic                 rsp_valid,
   input  logic [23:0]          rsp_data,
   output logic [NUM_PORTS-1:0] port_ready,
   output logic [NUM_PORTS-1:0] port_is_wavebird,
   output logic                 frame_overrun
);

   localparam int FC_W  = $clog2(FRAME_CYCLES + 1);
   localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);

   sched_state_t      state_q, state_d;
   logic [PORT_W-1:0] idx_q, idx_d;
   logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [PORT_W-1:0] cmd_port_q, cmd_port_d;
   cmd_op_t           cmd_op_q, cmd_op_d;
   logic [23:0]       cmd_id_q, cmd_id_d;
   logic              overrun_q, overrun_d;

   logic                 tick;
   logic                 load;
   logic [PORT_W-1:0]    load_idx;
   cmd_op_t              op_sel;
   logic [NUM_PORTS-1:0] is_current;
   logic [NUM_PORTS-1:0] pair_done, probe_rsp, poll_rsp, poll_timeout;
   logic                 next_strobe;
   port_state_t          pstate [NUM_PORTS];
   logic [23:0]          pid    [NUM_PORTS];
   logic [NUM_PORTS-1:0] pwb;

   assign tick        = (frame_cnt_q == FC_W'(FRAME_CYCLES - 1));
   assign frame_cnt_d = tick ? '0 : frame_cnt_q + FC_W'(1);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      tmo_d        = tmo_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_port_d   = cmd_port_q;
      cmd_op_d     = cmd_op_q;
      cmd_id_d     = cmd_id_q;
      overrun_d    = tick && (state_q != ST_IDLE);
      load         = 1'b0;
      load_idx     = idx_q;
      op_sel       = CMD_PROBE;
      pair_done    = '0;
      probe_rsp    = '0;
      poll_rsp     = '0;
      poll_timeout = '0;
      next_strobe  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick && enable) begin
               load     = 1'b1;
               load_idx = '0;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = ST_XMIT;
            end
         end
         ST_XMIT: begin
            if (cmd_done) begin
               if (cmd_op_q == CMD_PAIR) begin
                  pair_done[idx_q] = 1'b1;
                  state_d          = ST_NEXT;
               end else begin
                  tmo_d   = '0;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            tmo_d = tmo_q + TMO_W'(1);
            // A response landing on the timeout cycle still counts as an answer.
            if (rsp_valid) begin
               if (cmd_op_q == CMD_PROBE) probe_rsp[idx_q] = 1'b1;
               else                       poll_rsp[idx_q]  = 1'b1;
               state_d = ST_NEXT;
            end else if (tmo_q == TMO_W'(RSP_TIMEOUT - 1)) begin
               poll_timeout[idx_q] = (cmd_op_q == CMD_POLL);
               state_d             = ST_NEXT;
            end
         end
         ST_NEXT: begin
            next_strobe = 1'b1;
            if (idx_q == PORT_W'(NUM_PORTS - 1)) begin
               state_d = ST_IDLE;
            end else begin
               load     = 1'b1;
               load_idx = idx_q + PORT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         op_sel      = op_for_state(pstate[load_idx]);
         state_d     = ST_ISSUE;
         idx_d       = load_idx;
         cmd_valid_d = 1'b1;
         cmd_port_d  = load_idx;
         cmd_op_d    = op_sel;
         cmd_id_d    = '0;
         if (op_sel == CMD_PAIR) cmd_id_d = pid[load_idx];
`ifdef GC_RUMBLE_EN
         if (op_sel == CMD_POLL) cmd_id_d = {23'd0, rumble[load_idx]};
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         frame_cnt_q <= '0;
         tmo_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_port_q  <= '0;
         cmd_op_q    <= CMD_PROBE;
         cmd_id_q    <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
         tmo_q       <= tmo_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_port_q  <= cmd_port_d;
         cmd_op_q    <= cmd_op_d;
         cmd_id_q    <= cmd_id_d;
         overrun_q   <= overrun_d;
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign is_current[g] = (state_q != ST_IDLE) && (idx_q == PORT_W'(g));

      gc_port_tracker #(
         .MAX_MISSES (MAX_MISSES)
      ) u_trk (
         .clk          (clk),
         .rst_n        (rst_n),
         .force_reinit (force_reinit[g]),
         .is_current   (is_current[g]),
         .next_strobe  (next_strobe),
         .pair_done    (pair_done[g]),
         .probe_rsp    (probe_rsp[g]),
         .poll_rsp     (poll_rsp[g]),
         .poll_timeout (poll_timeout[g]),
         .rsp_data     (rsp_data),
         .state        (pstate[g]),
         .id           (pid[g]),
         .wavebird     (pwb[g])
      );

      assign port_ready[g]       = (pstate[g] == PS_POLL);
      assign port_is_wavebird[g] = pwb[g];
   end

   assign cmd_valid     = cmd_valid_q;
   assign cmd_port      = cmd_port_q;
   assign cmd_op        = cmd_op_q;
   assign cmd_id        = cmd_id_q;
   assign frame_overrun = overrun_q;

endmodule
